intersection_ctrl: RTL and testbench

Signal-phase controller for a four-phase intersection: pedestrian, up, down and turn. It latches phase requests from buttons and loop sensors and grants at most one green at a time, in round-robin order. Every change of phase passes through amber and then all-red clearance. Its green outputs feed the downstream phase-sequence cover and safety checker.

---
 rtl/intersection_pkg.sv | 40 ++++
 rtl/intersection_ctrl_phase_timer.sv | 29 ++
 rtl/intersection_ctrl.sv | 158 +++++++++++++++
 tb/tb_intersection_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared types and the round-robin phase scan for the intersection controller.
// Build option: INTERSECTION_PREEMPT_EN (consumed by intersection_ctrl).
package intersection_pkg;

    localparam int unsigned NUM_PHASES = 4;

    typedef enum logic [1:0] {
        PH_PED  = 2'd0,
        PH_UP   = 2'd1,
        PH_DOWN = 2'd2,
        PH_TURN = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        GREEN = 2'd2,
        AMBER = 2'd3
    } state_e;

    // First pending phase after cur (cur+1, +2, +3). cur itself is tried last so a
    // lone request for the resting phase out of IDLE is still served.
    function automatic phase_e next_phase(input logic [NUM_PHASES-1:0] pend,
                                          input phase_e                cur);
        phase_e     res;
        logic       found;
        logic [1:0] idx;
        res   = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            idx = cur + 2'(k);
            if (!found && pend[idx]) begin
                res   = phase_e'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter used for amber and all-red clearance intervals.
// Ports: clock, reset (async active-low), i_load/i_load_val load the count,
//        o_done_c is high while the count is zero.
module phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done_c
);

    logic [W-1:0] r_cnt;

    // Load wins; otherwise count down and stick at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Four-phase intersection signal controller: latches requests, grants one green at
// a time round-robin, and sequences every change through amber then all-red.
// Ports: clock, reset (async active-low); ped/up/down/turn_req request inputs;
//        pedestrian/up/down/turn_green, amber[3:0] (bit = phase), cur_phase.
// Build option: INTERSECTION_PREEMPT_EN adds input preempt (emergency override to UP).
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MAX_GREEN  = 12,
    parameter int unsigned AMBER_TIME = 3,
    parameter int unsigned CLEAR_TIME = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_req,
    input  logic       up_req,
    input  logic       down_req,
    input  logic       turn_req,
`ifdef INTERSECTION_PREEMPT_EN
    input  logic       preempt,
`endif
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic [3:0] amber,
    output logic [1:0] cur_phase
);

    localparam int unsigned GW   = $clog2(MAX_GREEN + 1);
    localparam int unsigned TMAX = (AMBER_TIME > CLEAR_TIME) ? AMBER_TIME : CLEAR_TIME;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    state_e          r_state, w_state_nxt;
    phase_e          r_cur_phase, w_phase_nxt;
    phase_e          r_next, w_next_nxt, w_next_eff;
    logic [3:0]      r_pend, w_pend_nxt;
    logic [3:0]      w_req, w_green_mask, w_clr_mask;
    logic [3:0]      r_green, r_amber;
    logic [GW-1:0]   r_green_cnt;
    logic            w_other_pend;
    logic            w_enter_green;
    logic            w_tmr_load, w_tmr_done;
    logic [TW-1:0]   w_tmr_val;
    logic            w_pre;

`ifdef INTERSECTION_PREEMPT_EN
    assign w_pre = preempt;
`else
    assign w_pre = 1'b0;
`endif

    assign w_req        = {turn_req, down_req, up_req, ped_req};
    assign w_green_mask = (r_state == GREEN) ? (4'(1) << r_cur_phase) : 4'b0;
    assign w_other_pend = |(r_pend & ~(4'(1) << r_cur_phase));
    // Preemption redirects the latched target to UP while it is asserted.
    assign w_next_eff   = w_pre ? PH_UP : r_next;

    phase_timer #(.W(TW)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done_c   (w_tmr_done)
    );

    // Next-state, next-target and timer control.
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_cur_phase;
        w_next_nxt    = r_next;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_enter_green = 1'b0;
        case (r_state)
            IDLE: begin
                if ((|(r_pend | w_req)) || w_pre) begin
                    w_state_nxt = CLEAR;
                    w_next_nxt  = w_pre ? PH_UP : next_phase(r_pend | w_req, r_cur_phase);
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(CLEAR_TIME - 1);
                end
            end
            CLEAR: begin
                if (w_pre) w_next_nxt = PH_UP;
                if (w_tmr_done) begin
                    w_state_nxt   = GREEN;
                    w_phase_nxt   = w_next_eff;
                    w_enter_green = 1'b1;
                end
            end
            GREEN: begin
                if (w_pre) begin
                    // Cut any non-UP green at once; UP is held for the duration.
                    if (r_cur_phase != PH_UP) begin
                        w_state_nxt = AMBER;
                        w_next_nxt  = PH_UP;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(AMBER_TIME - 1);
                    end
                end else if (w_other_pend && (r_green_cnt >= GW'(MIN_GREEN)) &&
                             (!w_req[r_cur_phase] || (r_green_cnt >= GW'(MAX_GREEN)))) begin
                    w_state_nxt = AMBER;
                    w_next_nxt  = next_phase(r_pend, r_cur_phase);
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(AMBER_TIME - 1);
                end
            end
            AMBER: begin
                if (w_pre) w_next_nxt = PH_UP;
                if (w_tmr_done) begin
                    w_state_nxt = CLEAR;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(CLEAR_TIME - 1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Requests for the green phase are presence only; grant clears beat new sets.
    assign w_clr_mask = w_enter_green ? (4'(1) << w_phase_nxt) : 4'b0;
    assign w_pend_nxt = (r_pend | (w_req & ~w_green_mask)) & ~w_clr_mask;

    // State, pending, green counter and registered lamp outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cur_phase <= PH_TURN;
            r_next      <= PH_PED;
            r_pend      <= '0;
            r_green_cnt <= '0;
            r_green     <= '0;
            r_amber     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_phase <= w_phase_nxt;
            r_next      <= w_next_nxt;
            r_pend      <= w_pend_nxt;
            if (w_enter_green) begin
                r_green_cnt <= GW'(1);
            end else if ((r_state == GREEN) && (r_green_cnt < GW'(MAX_GREEN))) begin
                r_green_cnt <= r_green_cnt + GW'(1);
            end
            r_green <= (w_state_nxt == GREEN) ? (4'(1) << w_phase_nxt) : 4'b0;
            r_amber <= (w_state_nxt == AMBER) ? (4'(1) << w_phase_nxt) : 4'b0;
        end
    end

    assign pedestrian_green = r_green[PH_PED];
    assign up_green         = r_green[PH_UP];
    assign down_green       = r_green[PH_DOWN];
    assign turn_green       = r_green[PH_TURN];
    assign amber            = r_amber;
    assign cur_phase        = r_cur_phase;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: stimulus pushes per-cycle expected lamps,
// a monitor pops and compares each cycle. Preempt scenario under INTERSECTION_PREEMPT_EN.
module tb_intersection_ctrl;

    logic       clock;
    logic       reset;
    logic       ped_req, up_req, down_req, turn_req;
    logic       pedestrian_green, up_green, down_green, turn_green;
    logic [3:0] amber;
    logic [1:0] cur_phase;
`ifdef INTERSECTION_PREEMPT_EN
    logic       preempt;
    logic       pre_v;
`endif

    intersection_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .ped_req          (ped_req),
        .up_req           (up_req),
        .down_req         (down_req),
        .turn_req         (turn_req),
`ifdef INTERSECTION_PREEMPT_EN
        .preempt          (preempt),
`endif
        .pedestrian_green (pedestrian_green),
        .up_green         (up_green),
        .down_green       (down_green),
        .turn_green       (turn_green),
        .amber            (amber),
        .cur_phase        (cur_phase)
    );

    typedef struct packed {
        logic [3:0]  g;
        logic [3:0]  a;
        logic [1:0]  cp;
        logic [7:0]  tid;
        logic [15:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tid    = 0;
    int   cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input logic [3:0] g, input logic [3:0] a, input logic [1:0] cp);
        exp_t e;
        e.g   = g;
        e.a   = a;
        e.cp  = cp;
        e.tid = 8'(tid);
        e.cyc = 16'(cyc);
        exp_q.push_back(e);
        cyc++;
    endtask

    // One cycle: drive requests at the falling edge and queue the lamps expected now.
    task automatic step(input logic [3:0] req, input logic [3:0] g, input logic [3:0] a,
                        input logic [1:0] cp);
        @(negedge clock);
        {turn_req, down_req, up_req, ped_req} = req;
`ifdef INTERSECTION_PREEMPT_EN
        preempt = pre_v;
`endif
        push(g, a, cp);
    endtask

    task automatic hold(input int n, input logic [3:0] req, input logic [3:0] g,
                        input logic [3:0] a, input logic [1:0] cp);
        repeat (n) step(req, g, a, cp);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        push(4'b0, 4'b0, 2'd3);
        cyc = 0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        {turn_req, down_req, up_req, ped_req} = 4'b0;
        cyc = 1000;
        push(4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        release_reset();
    endtask

    // Monitor: pop and compare once per cycle, away from the rising edge.
    initial begin
        exp_t e;
        logic [3:0] g;
        forever begin
            @(negedge clock);
            #1;
            g = {turn_green, down_green, up_green, pedestrian_green};
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (g !== e.g || amber !== e.a || cur_phase !== e.cp) begin
                    errors++;
                    $display("FAIL lamps t%0d c%0d: got green=%b amber=%b phase=%0d, want green=%b amber=%b phase=%0d",
                             e.tid, e.cyc, g, amber, cur_phase, e.g, e.a, e.cp);
                end
                checks++;
                if ($countones(g) > 1 || (|g && |amber)) begin
                    errors++;
                    $display("FAIL exclusive t%0d c%0d: got green=%b amber=%b, want one-hot-or-zero green and no green with amber",
                             e.tid, e.cyc, g, amber);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        {turn_req, down_req, up_req, ped_req} = 4'b0;
`ifdef INTERSECTION_PREEMPT_EN
        preempt = 1'b0;
        pre_v   = 1'b0;
`endif

        // T1: single up request from IDLE, green rests with nothing else pending.
        tid = 1;
        apply_reset();
        step(4'b0010, 4'b0, 4'b0, 2'd3);
        hold(2,  4'b0, 4'b0, 4'b0, 2'd3);
        hold(15, 4'b0, 4'b0010, 4'b0, 2'd1);

        // T2: gap-out after minimum green, then amber, clear and pedestrian green.
        tid = 2;
        apply_reset();
        step(4'b0010, 4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        step(4'b0000, 4'b0010, 4'b0, 2'd1);
        step(4'b0001, 4'b0010, 4'b0, 2'd1);
        hold(2, 4'b0, 4'b0010, 4'b0, 2'd1);
        hold(3, 4'b0, 4'b0, 4'b0010, 2'd1);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd1);
        hold(8, 4'b0, 4'b0001, 4'b0, 2'd0);

        // T3: up held present with down pending -> max-out after 12 green cycles.
        tid = 3;
        hold(2, 4'b0010, 4'b0001, 4'b0, 2'd0);
        hold(3, 4'b0010, 4'b0, 4'b0001, 2'd0);
        hold(2, 4'b0010, 4'b0, 4'b0, 2'd0);
        step(4'b0010, 4'b0010, 4'b0, 2'd1);
        step(4'b0110, 4'b0010, 4'b0, 2'd1);
        hold(10, 4'b0010, 4'b0010, 4'b0, 2'd1);
        hold(3, 4'b0, 4'b0, 4'b0010, 2'd1);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd1);
        hold(6, 4'b0, 4'b0100, 4'b0, 2'd2);

        // T4: all four requests together -> ped, up, down, turn in order.
        tid = 4;
        apply_reset();
        step(4'b1111, 4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        hold(4, 4'b0, 4'b0001, 4'b0, 2'd0);
        hold(3, 4'b0, 4'b0, 4'b0001, 2'd0);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd0);
        hold(4, 4'b0, 4'b0010, 4'b0, 2'd1);
        hold(3, 4'b0, 4'b0, 4'b0010, 2'd1);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd1);
        hold(4, 4'b0, 4'b0100, 4'b0, 2'd2);
        hold(3, 4'b0, 4'b0, 4'b0100, 2'd2);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd2);
        hold(6, 4'b0, 4'b1000, 4'b0, 2'd3);

        // T5: asynchronous reset in the middle of amber; pending requests discarded.
        tid = 5;
        apply_reset();
        step(4'b1111, 4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        hold(4, 4'b0, 4'b0001, 4'b0, 2'd0);
        hold(2, 4'b0, 4'b0, 4'b0001, 2'd0);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({turn_green, down_green, up_green, pedestrian_green} !== 4'b0 ||
            amber !== 4'b0 || cur_phase !== 2'd3) begin
            errors++;
            $display("FAIL async_reset: got green=%b amber=%b phase=%0d, want green=0000 amber=0000 phase=3",
                     {turn_green, down_green, up_green, pedestrian_green}, amber, cur_phase);
        end
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        release_reset();
        hold(6, 4'b0, 4'b0, 4'b0, 2'd3);

`ifdef INTERSECTION_PREEMPT_EN
        // T6: preempt on turn-green cycle 2 -> immediate amber, clear, UP held.
        tid = 6;
        apply_reset();
        step(4'b1100, 4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        hold(4, 4'b0, 4'b0100, 4'b0, 2'd2);
        hold(3, 4'b0, 4'b0, 4'b0100, 2'd2);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd2);
        step(4'b0, 4'b1000, 4'b0, 2'd3);
        pre_v = 1'b1;
        step(4'b0, 4'b1000, 4'b0, 2'd3);
        hold(3, 4'b0, 4'b0, 4'b1000, 2'd3);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd3);
        hold(2, 4'b0, 4'b0010, 4'b0, 2'd1);
        step(4'b0001, 4'b0010, 4'b0, 2'd1);
        hold(13, 4'b0, 4'b0010, 4'b0, 2'd1);
        pre_v = 1'b0;
        step(4'b0, 4'b0010, 4'b0, 2'd1);
        hold(3, 4'b0, 4'b0, 4'b0010, 2'd1);
        hold(2, 4'b0, 4'b0, 4'b0, 2'd1);
        hold(3, 4'b0, 4'b0001, 4'b0, 2'd0);
`endif

        @(negedge clock);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
